// File: rtl/exe_stage_mc.sv
// Execute stage: forwarding muxes, shifter/ALU, branch target and an iterative
// MUL/MLA unit, all feeding an EX/MEM output register with freeze/flush control.
module exe_stage_mc #(
   parameter int HAS_MUL  = 1,
   parameter int MUL_STEP = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        flush,
   input  logic        valid_in,
   input  logic        wb_en_in,
   input  logic        mem_r_en_in,
   input  logic        mem_w_en_in,
   input  logic        b_in,
   input  logic        s_in,
   input  logic        i_in,
   input  logic [3:0]  exe_cmd_in,
   input  logic [31:0] pc_in,
   input  logic [31:0] val_rn_in,
   input  logic [31:0] val_rm_in,
   input  logic [31:0] val_rs_in,
   input  logic [11:0] shift_operand_in,
   input  logic [23:0] imm24_in,
   input  logic [3:0]  dest_in,
   input  logic [3:0]  status_in,
   input  logic [1:0]  fwd_sel1,
   input  logic [1:0]  fwd_sel2,
   input  logic [31:0] fwd_mem_val,
   input  logic [31:0] fwd_wb_val,
   output logic        wb_en_out,
   output logic        mem_r_en_out,
   output logic        mem_w_en_out,
   output logic [31:0] alu_res_out,
   output logic [31:0] val_rm_out,
   output logic [3:0]  dest_out,
   output logic [3:0]  status_out,
   output logic        status_we,
   output logic        branch_taken,
   output logic [31:0] branch_addr,
   output logic        busy
);

   localparam int         N_ITER    = 32 / MUL_STEP;
   localparam logic [5:0] LAST_ITER = 6'(N_ITER - 1);

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam logic [3:0] CMD_MUL = 4'b1010;
   localparam logic [3:0] CMD_MLA = 4'b1011;

   typedef enum logic {ST_IDLE, ST_RUN} mulState_t;
   typedef enum logic [1:0] {FL_NONE, FL_LOGIC, FL_ARITH} flagClass_t;

   mulState_t   r_state, w_stateNext;
   flagClass_t  w_flagClass;

   logic [31:0] w_op1, w_rm, w_val2, w_immExt, w_immRot, w_shifted;
   logic [31:0] w_addB, w_aluRes, w_brAddr, w_partial, w_accNext;
   logic [32:0] w_sum;
   logic [4:0]  w_rotAmt, w_shAmt;
   logic [3:0]  w_flags;
   logic        w_cin, w_isSub, w_isMul;
   logic        w_busy, w_mulStart, w_mulAdvance, w_mulDone, w_lastIter;

   logic [31:0] r_mulA, r_mulB, r_acc;
   logic [5:0]  r_cnt;
   logic [3:0]  r_mulDest;
   logic [1:0]  r_mulCV;
   logic        r_mulWb, r_mulMemR, r_mulMemW, r_mulS;

   logic [31:0] w_nRes, w_nRm, w_nBrAddr;
   logic [3:0]  w_nDest, w_nStatus;
   logic        w_outLoad, w_nWb, w_nMemR, w_nMemW, w_nStatusWe, w_nBrTaken;

   logic [31:0] r_res, r_rm, r_brAddr;
   logic [3:0]  r_dest, r_status;
   logic        r_wb, r_memR, r_memW, r_statusWe, r_brTaken;

   always_comb begin
      case (fwd_sel1)
         2'd1:    w_op1 = fwd_mem_val;
         2'd2:    w_op1 = fwd_wb_val;
         default: w_op1 = val_rn_in;
      endcase
      case (fwd_sel2)
         2'd1:    w_rm = fwd_mem_val;
         2'd2:    w_rm = fwd_wb_val;
         default: w_rm = val_rm_in;
      endcase
   end

   // Shift amounts of zero fall out of every formula as "no shift".
   always_comb begin
      w_immExt = {24'b0, shift_operand_in[7:0]};
      w_rotAmt = {shift_operand_in[11:8], 1'b0};
      w_immRot = (w_immExt >> w_rotAmt) | (w_immExt << (6'd32 - {1'b0, w_rotAmt}));
      w_shAmt  = shift_operand_in[11:7];
      case (shift_operand_in[6:5])
         2'b00:   w_shifted = w_rm << w_shAmt;
         2'b01:   w_shifted = w_rm >> w_shAmt;
         2'b10:   w_shifted = $signed(w_rm) >>> w_shAmt;
         default: w_shifted = (w_rm >> w_shAmt) | (w_rm << (6'd32 - {1'b0, w_shAmt}));
      endcase
      if ((mem_r_en_in || mem_w_en_in) && !i_in)
         w_val2 = {20'b0, shift_operand_in};
      else if (i_in)
         w_val2 = w_immRot;
      else
         w_val2 = w_shifted;
   end

   // Subtraction is op1 + ~val2 + cin, so one adder and one overflow rule serve both.
   always_comb begin
      w_isSub = (exe_cmd_in == CMD_SUB) || (exe_cmd_in == CMD_SBC);
      case (exe_cmd_in)
         CMD_ADC, CMD_SBC: w_cin = status_in[1];
         CMD_SUB:          w_cin = 1'b1;
         default:          w_cin = 1'b0;
      endcase
      w_addB = w_isSub ? ~w_val2 : w_val2;
      w_sum  = {1'b0, w_op1} + {1'b0, w_addB} + {32'b0, w_cin};
      w_aluRes    = '0;
      w_flagClass = FL_NONE;
      case (exe_cmd_in)
         CMD_MOV: begin w_aluRes = w_val2;          w_flagClass = FL_LOGIC; end
         CMD_MVN: begin w_aluRes = ~w_val2;         w_flagClass = FL_LOGIC; end
         CMD_AND: begin w_aluRes = w_op1 & w_val2;  w_flagClass = FL_LOGIC; end
         CMD_ORR: begin w_aluRes = w_op1 | w_val2;  w_flagClass = FL_LOGIC; end
         CMD_EOR: begin w_aluRes = w_op1 ^ w_val2;  w_flagClass = FL_LOGIC; end
         CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
            w_aluRes    = w_sum[31:0];
            w_flagClass = FL_ARITH;
         end
         default: begin w_aluRes = '0; w_flagClass = FL_NONE; end
      endcase
      case (w_flagClass)
         FL_LOGIC: w_flags = {w_aluRes[31], w_aluRes == 32'b0, status_in[1:0]};
         FL_ARITH: w_flags = {w_aluRes[31], w_aluRes == 32'b0, w_sum[32],
                              (w_op1[31] == w_addB[31]) && (w_sum[31] != w_op1[31])};
         default:  w_flags = status_in;
      endcase
      w_brAddr = pc_in + {{6{imm24_in[23]}}, imm24_in, 2'b00};
      w_isMul  = (HAS_MUL != 0) && ((exe_cmd_in == CMD_MUL) || (exe_cmd_in == CMD_MLA));
   end

   always_comb begin
      w_partial = '0;
      for (int j = 0; j < MUL_STEP; j++)
         if (r_mulB[j]) w_partial = w_partial + (r_mulA << j);
      w_accNext = r_acc + w_partial;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_IDLE: if (valid_in && w_isMul && !freeze && !flush) w_stateNext = ST_RUN;
         ST_RUN:  if (flush || (!freeze && w_lastIter))         w_stateNext = ST_IDLE;
         default: w_stateNext = ST_IDLE;
      endcase
   end

   always_comb begin
      w_busy       = (r_state == ST_RUN);
      w_lastIter   = (r_cnt == LAST_ITER);
      w_mulStart   = !w_busy && valid_in && w_isMul && !freeze && !flush;
      w_mulAdvance = w_busy && !freeze && !flush;
      w_mulDone    = w_mulAdvance && w_lastIter;
   end

   // Operands and the instruction's control bits are latched at start so the
   // upstream stage is free to change while the unit iterates.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mulA <= '0; r_mulB <= '0; r_acc <= '0; r_cnt <= '0;
         r_mulDest <= '0; r_mulCV <= '0;
         r_mulWb <= 1'b0; r_mulMemR <= 1'b0; r_mulMemW <= 1'b0; r_mulS <= 1'b0;
      end else if (w_mulStart) begin
         r_mulA    <= w_rm;
         r_mulB    <= val_rs_in;
         r_acc     <= (exe_cmd_in == CMD_MLA) ? w_op1 : 32'b0;
         r_cnt     <= '0;
         r_mulDest <= dest_in;
         r_mulCV   <= status_in[1:0];
         r_mulWb   <= wb_en_in;
         r_mulMemR <= mem_r_en_in;
         r_mulMemW <= mem_w_en_in;
         r_mulS    <= s_in;
      end else if (w_busy && flush) begin
         r_cnt <= '0;
      end else if (w_mulAdvance) begin
         r_mulA <= r_mulA << MUL_STEP;
         r_mulB <= r_mulB >> MUL_STEP;
         r_acc  <= w_accNext;
         r_cnt  <= r_cnt + 6'd1;
      end
   end

   // Anything not explicitly filled in below is a bubble (all zero).
   always_comb begin
      w_outLoad = 1'b0;
      w_nWb = 1'b0; w_nMemR = 1'b0; w_nMemW = 1'b0;
      w_nRes = '0; w_nRm = '0; w_nDest = '0; w_nStatus = '0;
      w_nStatusWe = 1'b0; w_nBrTaken = 1'b0; w_nBrAddr = '0;
      if (flush) begin
         w_outLoad = 1'b1;
      end else if (w_busy) begin
         if (w_mulDone) begin
            w_outLoad   = 1'b1;
            w_nWb       = r_mulWb;
            w_nMemR     = r_mulMemR;
            w_nMemW     = r_mulMemW;
            w_nRes      = w_accNext;
            w_nDest     = r_mulDest;
            w_nStatus   = {w_accNext[31], w_accNext == 32'b0, r_mulCV};
            w_nStatusWe = r_mulS;
         end
      end else if (!freeze) begin
         w_outLoad = 1'b1;
         if (valid_in && !w_isMul) begin
            w_nWb       = wb_en_in;
            w_nMemR     = mem_r_en_in;
            w_nMemW     = mem_w_en_in;
            w_nRes      = w_aluRes;
            w_nRm       = w_rm;
            w_nDest     = dest_in;
            w_nStatus   = w_flags;
            w_nStatusWe = s_in;
            w_nBrTaken  = b_in;
            w_nBrAddr   = w_brAddr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wb <= 1'b0; r_memR <= 1'b0; r_memW <= 1'b0;
         r_res <= '0; r_rm <= '0; r_dest <= '0; r_status <= '0;
         r_statusWe <= 1'b0; r_brTaken <= 1'b0; r_brAddr <= '0;
      end else if (w_outLoad) begin
         r_wb       <= w_nWb;
         r_memR     <= w_nMemR;
         r_memW     <= w_nMemW;
         r_res      <= w_nRes;
         r_rm       <= w_nRm;
         r_dest     <= w_nDest;
         r_status   <= w_nStatus;
         r_statusWe <= w_nStatusWe;
         r_brTaken  <= w_nBrTaken;
         r_brAddr   <= w_nBrAddr;
      end
   end

   assign wb_en_out    = r_wb;
   assign mem_r_en_out = r_memR;
   assign mem_w_en_out = r_memW;
   assign alu_res_out  = r_res;
   assign val_rm_out   = r_rm;
   assign dest_out     = r_dest;
   assign status_out   = r_status;
   assign status_we    = r_statusWe;
   assign branch_taken = r_brTaken;
   assign branch_addr  = r_brAddr;
   assign busy         = w_busy;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc: three instances (MUL_STEP 2, 1, 8) share
// one stimulus; most checks look at the MUL_STEP=2 instance.
module tb_exe_stage_mc;

   logic        clk, rst, freeze, flush, validIn, wbEnIn, memREnIn, memWEnIn, bIn, sIn, iIn;
   logic [3:0]  exeCmdIn, destIn, statusIn;
   logic [31:0] pcIn, valRnIn, valRmIn, valRsIn, fwdMemVal, fwdWbVal;
   logic [11:0] shiftOperandIn;
   logic [23:0] imm24In;
   logic [1:0]  fwdSel1, fwdSel2;

   logic        wbEn_s2, memR_s2, memW_s2, statusWe_s2, brTaken_s2, busy_s2;
   logic [31:0] aluRes_s2, valRm_s2, brAddr_s2;
   logic [3:0]  dest_s2, status_s2;
   logic        wbEn_s1, memR_s1, memW_s1, statusWe_s1, brTaken_s1, busy_s1;
   logic [31:0] aluRes_s1, valRm_s1, brAddr_s1;
   logic [3:0]  dest_s1, status_s1;
   logic        wbEn_s8, memR_s8, memW_s8, statusWe_s8, brTaken_s8, busy_s8;
   logic [31:0] aluRes_s8, valRm_s8, brAddr_s8;
   logic [3:0]  dest_s8, status_s8;

   int errCount   = 0;
   int checkCount = 0;

   exe_stage_mc #(.HAS_MUL(1), .MUL_STEP(2)) u_dut2 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(validIn),
      .wb_en_in(wbEnIn), .mem_r_en_in(memREnIn), .mem_w_en_in(memWEnIn), .b_in(bIn),
      .s_in(sIn), .i_in(iIn), .exe_cmd_in(exeCmdIn), .pc_in(pcIn), .val_rn_in(valRnIn),
      .val_rm_in(valRmIn), .val_rs_in(valRsIn), .shift_operand_in(shiftOperandIn),
      .imm24_in(imm24In), .dest_in(destIn), .status_in(statusIn), .fwd_sel1(fwdSel1),
      .fwd_sel2(fwdSel2), .fwd_mem_val(fwdMemVal), .fwd_wb_val(fwdWbVal),
      .wb_en_out(wbEn_s2), .mem_r_en_out(memR_s2), .mem_w_en_out(memW_s2),
      .alu_res_out(aluRes_s2), .val_rm_out(valRm_s2), .dest_out(dest_s2),
      .status_out(status_s2), .status_we(statusWe_s2), .branch_taken(brTaken_s2),
      .branch_addr(brAddr_s2), .busy(busy_s2));

   exe_stage_mc #(.HAS_MUL(1), .MUL_STEP(1)) u_dut1 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(validIn),
      .wb_en_in(wbEnIn), .mem_r_en_in(memREnIn), .mem_w_en_in(memWEnIn), .b_in(bIn),
      .s_in(sIn), .i_in(iIn), .exe_cmd_in(exeCmdIn), .pc_in(pcIn), .val_rn_in(valRnIn),
      .val_rm_in(valRmIn), .val_rs_in(valRsIn), .shift_operand_in(shiftOperandIn),
      .imm24_in(imm24In), .dest_in(destIn), .status_in(statusIn), .fwd_sel1(fwdSel1),
      .fwd_sel2(fwdSel2), .fwd_mem_val(fwdMemVal), .fwd_wb_val(fwdWbVal),
      .wb_en_out(wbEn_s1), .mem_r_en_out(memR_s1), .mem_w_en_out(memW_s1),
      .alu_res_out(aluRes_s1), .val_rm_out(valRm_s1), .dest_out(dest_s1),
      .status_out(status_s1), .status_we(statusWe_s1), .branch_taken(brTaken_s1),
      .branch_addr(brAddr_s1), .busy(busy_s1));

   exe_stage_mc #(.HAS_MUL(1), .MUL_STEP(8)) u_dut8 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(validIn),
      .wb_en_in(wbEnIn), .mem_r_en_in(memREnIn), .mem_w_en_in(memWEnIn), .b_in(bIn),
      .s_in(sIn), .i_in(iIn), .exe_cmd_in(exeCmdIn), .pc_in(pcIn), .val_rn_in(valRnIn),
      .val_rm_in(valRmIn), .val_rs_in(valRsIn), .shift_operand_in(shiftOperandIn),
      .imm24_in(imm24In), .dest_in(destIn), .status_in(statusIn), .fwd_sel1(fwdSel1),
      .fwd_sel2(fwdSel2), .fwd_mem_val(fwdMemVal), .fwd_wb_val(fwdWbVal),
      .wb_en_out(wbEn_s8), .mem_r_en_out(memR_s8), .mem_w_en_out(memW_s8),
      .alu_res_out(aluRes_s8), .val_rm_out(valRm_s8), .dest_out(dest_s8),
      .status_out(status_s8), .status_we(statusWe_s8), .branch_taken(brTaken_s8),
      .branch_addr(brAddr_s8), .busy(busy_s8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      freeze = 1'b0; flush = 1'b0; validIn = 1'b0; wbEnIn = 1'b0; memREnIn = 1'b0;
      memWEnIn = 1'b0; bIn = 1'b0; sIn = 1'b0; iIn = 1'b0; exeCmdIn = 4'b0000;
      pcIn = '0; valRnIn = '0; valRmIn = '0; valRsIn = '0; shiftOperandIn = '0;
      imm24In = '0; destIn = '0; statusIn = '0; fwdSel1 = 2'd0; fwdSel2 = 2'd0;
      fwdMemVal = '0; fwdWbVal = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clearInputs();
      validIn = 1'b1; wbEnIn = 1'b1; bIn = 1'b1; sIn = 1'b1; exeCmdIn = 4'b0001; iIn = 1'b1;
      shiftOperandIn = 12'h0FF;
      tick(); tick();
      checkCount++; if (aluRes_s2 !== 32'h0) begin errCount++; $display("[TB] FAIL reset_res: got %h expected 0", aluRes_s2); end
      checkCount++; if ({wbEn_s2, memR_s2, memW_s2, statusWe_s2, brTaken_s2} !== 5'b0) begin errCount++; $display("[TB] FAIL reset_ctl: got %b expected 00000", {wbEn_s2, memR_s2, memW_s2, statusWe_s2, brTaken_s2}); end
      checkCount++; if ({status_s2, dest_s2} !== 8'h0 || brAddr_s2 !== 32'h0 || valRm_s2 !== 32'h0) begin errCount++; $display("[TB] FAIL reset_data: status %h dest %h addr %h rm %h expected 0", status_s2, dest_s2, brAddr_s2, valRm_s2); end
      checkCount++; if ({busy_s2, busy_s1, busy_s8} !== 3'b000) begin errCount++; $display("[TB] FAIL reset_busy: got %b expected 000", {busy_s2, busy_s1, busy_s8}); end
      rst = 1'b0;
      clearInputs();
      tick();
   endtask

   task automatic test_add();
      clearInputs();
      validIn = 1'b1; wbEnIn = 1'b1; sIn = 1'b1; exeCmdIn = 4'b0010;
      valRnIn = 32'hFFFF_FFFF; iIn = 1'b1; shiftOperandIn = 12'h001; destIn = 4'd3;
      tick();
      checkCount++; if (aluRes_s2 !== 32'h0) begin errCount++; $display("[TB] FAIL add_res: got %h expected 00000000", aluRes_s2); end
      checkCount++; if (status_s2 !== 4'b0110) begin errCount++; $display("[TB] FAIL add_flags: got %b expected 0110", status_s2); end
      checkCount++; if (statusWe_s2 !== 1'b1 || wbEn_s2 !== 1'b1 || dest_s2 !== 4'd3) begin errCount++; $display("[TB] FAIL add_ctl: we %b wb %b dest %0d expected 1 1 3", statusWe_s2, wbEn_s2, dest_s2); end
   endtask

   task automatic test_sub_fwd();
      clearInputs();
      validIn = 1'b1; sIn = 1'b1; exeCmdIn = 4'b0100; fwdSel1 = 2'd1;
      fwdMemVal = 32'd5; valRnIn = 32'd99; iIn = 1'b1; shiftOperandIn = 12'h007;
      tick();
      checkCount++; if (aluRes_s2 !== 32'hFFFF_FFFE) begin errCount++; $display("[TB] FAIL sub_res: got %h expected fffffffe", aluRes_s2); end
      checkCount++; if (status_s2 !== 4'b1000) begin errCount++; $display("[TB] FAIL sub_flags: got %b expected 1000", status_s2); end
   endtask

   task automatic test_val2();
      clearInputs();
      validIn = 1'b1; exeCmdIn = 4'b0001; iIn = 1'b1; shiftOperandIn = 12'h4FF;
      tick();
      checkCount++; if (aluRes_s2 !== 32'hFF00_0000) begin errCount++; $display("[TB] FAIL imm_rot: got %h expected ff000000", aluRes_s2); end
      iIn = 1'b0; valRmIn = 32'h1234_5678; fwdSel2 = 2'd2; fwdWbVal = 32'h8000_0000; shiftOperandIn = 12'h240;
      tick();
      checkCount++; if (aluRes_s2 !== 32'hF800_0000) begin errCount++; $display("[TB] FAIL asr: got %h expected f8000000", aluRes_s2); end
      checkCount++; if (valRm_s2 !== 32'h8000_0000) begin errCount++; $display("[TB] FAIL fwd_rm: got %h expected 80000000", valRm_s2); end
      fwdSel2 = 2'd0; valRmIn = 32'h0000_000F; shiftOperandIn = 12'h260;
      tick();
      checkCount++; if (aluRes_s2 !== 32'hF000_0000) begin errCount++; $display("[TB] FAIL ror: got %h expected f0000000", aluRes_s2); end
      exeCmdIn = 4'b0010; memREnIn = 1'b1; valRnIn = 32'h0000_1000; shiftOperandIn = 12'h123;
      tick();
      checkCount++; if (aluRes_s2 !== 32'h0000_1123) begin errCount++; $display("[TB] FAIL ldr_res: got %h expected 00001123", aluRes_s2); end
      checkCount++; if (memR_s2 !== 1'b1) begin errCount++; $display("[TB] FAIL ldr_memr: got %b expected 1", memR_s2); end
   endtask

   task automatic test_undef();
      clearInputs();
      validIn = 1'b1; sIn = 1'b1; exeCmdIn = 4'b0000; statusIn = 4'b1010;
      valRnIn = 32'd7; iIn = 1'b1; shiftOperandIn = 12'h005;
      tick();
      checkCount++; if (aluRes_s2 !== 32'h0 || status_s2 !== 4'b1010) begin errCount++; $display("[TB] FAIL undef: res %h flags %b expected 0 1010", aluRes_s2, status_s2); end
   endtask

   task automatic test_freeze_flush_single();
      clearInputs();
      validIn = 1'b1; wbEnIn = 1'b1; exeCmdIn = 4'b0010; valRnIn = 32'd2; iIn = 1'b1; shiftOperandIn = 12'h003;
      tick();
      checkCount++; if (aluRes_s2 !== 32'd5) begin errCount++; $display("[TB] FAIL pre_freeze: got %0d expected 5", aluRes_s2); end
      freeze = 1'b1; valRnIn = 32'd10; wbEnIn = 1'b0;
      tick();
      checkCount++; if (aluRes_s2 !== 32'd5 || wbEn_s2 !== 1'b1) begin errCount++; $display("[TB] FAIL freeze_hold: res %0d wb %b expected 5 1", aluRes_s2, wbEn_s2); end
      flush = 1'b1; wbEnIn = 1'b1;
      tick();
      checkCount++; if (wbEn_s2 !== 1'b0 || statusWe_s2 !== 1'b0) begin errCount++; $display("[TB] FAIL flush_over_freeze: wb %b we %b expected 0 0", wbEn_s2, statusWe_s2); end
   endtask

   task automatic test_branch();
      clearInputs();
      validIn = 1'b1; bIn = 1'b1; pcIn = 32'h100; imm24In = 24'hFFFFFE;
      tick();
      checkCount++; if (brAddr_s2 !== 32'h0000_00F8) begin errCount++; $display("[TB] FAIL br_addr: got %h expected 000000f8", brAddr_s2); end
      checkCount++; if (brTaken_s2 !== 1'b1) begin errCount++; $display("[TB] FAIL br_taken: got %b expected 1", brTaken_s2); end
      flush = 1'b1;
      tick();
      checkCount++; if (brTaken_s2 !== 1'b0) begin errCount++; $display("[TB] FAIL br_flush: got %b expected 0", brTaken_s2); end
   endtask

   task automatic startMla();
      clearInputs();
      validIn = 1'b1; wbEnIn = 1'b1; sIn = 1'b1; exeCmdIn = 4'b1011; destIn = 4'd9;
      valRmIn = 32'd7; valRsIn = 32'd6; valRnIn = 32'd3; statusIn = 4'b0011;
      tick();
      validIn = 1'b0;
   endtask

   task automatic test_mla_latency();
      int cnt2 = 0, cnt1 = 0, cnt8 = 0;
      logic done2 = 0, done1 = 0, done8 = 0;
      logic [31:0] res2 = '0, res1 = '0, res8 = '0;
      logic [3:0] st2 = '0, st1 = '0, st8 = '0, d2 = '0;
      logic we2 = 0, wb2 = 0;
      startMla();
      checkCount++; if (wbEn_s2 !== 1'b0 || statusWe_s2 !== 1'b0) begin errCount++; $display("[TB] FAIL mla_start_bubble: wb %b we %b expected 0 0", wbEn_s2, statusWe_s2); end
      for (int k = 0; k < 40; k++) begin
         if (busy_s2) cnt2++; else if (!done2) begin done2 = 1; res2 = aluRes_s2; st2 = status_s2; we2 = statusWe_s2; wb2 = wbEn_s2; d2 = dest_s2; end
         if (busy_s1) cnt1++; else if (!done1) begin done1 = 1; res1 = aluRes_s1; st1 = status_s1; end
         if (busy_s8) cnt8++; else if (!done8) begin done8 = 1; res8 = aluRes_s8; st8 = status_s8; end
         tick();
      end
      checkCount++; if (cnt2 !== 16) begin errCount++; $display("[TB] FAIL mla2_busy: got %0d cycles expected 16", cnt2); end
      checkCount++; if (res2 !== 32'd45 || st2 !== 4'b0011) begin errCount++; $display("[TB] FAIL mla2_res: res %0d flags %b expected 45 0011", res2, st2); end
      checkCount++; if (we2 !== 1'b1 || wb2 !== 1'b1 || d2 !== 4'd9) begin errCount++; $display("[TB] FAIL mla2_ctl: we %b wb %b dest %0d expected 1 1 9", we2, wb2, d2); end
      checkCount++; if (cnt1 !== 32) begin errCount++; $display("[TB] FAIL mla1_busy: got %0d cycles expected 32", cnt1); end
      checkCount++; if (res1 !== 32'd45 || st1 !== 4'b0011) begin errCount++; $display("[TB] FAIL mla1_res: res %0d flags %b expected 45 0011", res1, st1); end
      checkCount++; if (cnt8 !== 4) begin errCount++; $display("[TB] FAIL mla8_busy: got %0d cycles expected 4", cnt8); end
      checkCount++; if (res8 !== 32'd45 || st8 !== 4'b0011) begin errCount++; $display("[TB] FAIL mla8_res: res %0d flags %b expected 45 0011", res8, st8); end
   endtask

   task automatic test_mul_freeze();
      int cnt2 = 0;
      logic done2 = 0;
      logic [31:0] res2 = '0;
      startMla();
      for (int k = 0; k < 40; k++) begin
         if (busy_s2) cnt2++; else if (!done2) begin done2 = 1; res2 = aluRes_s2; end
         freeze = (k >= 4 && k <= 6);
         tick();
      end
      freeze = 1'b0;
      checkCount++; if (cnt2 !== 19) begin errCount++; $display("[TB] FAIL mul_freeze_busy: got %0d cycles expected 19", cnt2); end
      checkCount++; if (res2 !== 32'd45) begin errCount++; $display("[TB] FAIL mul_freeze_res: got %0d expected 45", res2); end
   endtask

   task automatic test_mul_flush();
      startMla();
      for (int k = 0; k < 4; k++) tick();
      checkCount++; if (busy_s2 !== 1'b1) begin errCount++; $display("[TB] FAIL flush_pre_busy: got %b expected 1", busy_s2); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkCount++; if (busy_s2 !== 1'b0) begin errCount++; $display("[TB] FAIL flush_busy: got %b expected 0", busy_s2); end
      checkCount++; if (statusWe_s2 !== 1'b0 || wbEn_s2 !== 1'b0) begin errCount++; $display("[TB] FAIL flush_bubble: we %b wb %b expected 0 0", statusWe_s2, wbEn_s2); end
      for (int k = 0; k < 16; k++) tick();
      checkCount++; if (statusWe_s2 !== 1'b0 || busy_s2 !== 1'b0) begin errCount++; $display("[TB] FAIL flush_no_late_write: we %b busy %b expected 0 0", statusWe_s2, busy_s2); end
   endtask

   task automatic test_reset_mid();
      startMla();
      for (int k = 0; k < 3; k++) tick();
      rst = 1'b1;
      tick();
      checkCount++; if (busy_s2 !== 1'b0) begin errCount++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy_s2); end
      rst = 1'b0;
      clearInputs();
      validIn = 1'b1; wbEnIn = 1'b1; sIn = 1'b1; bIn = 1'b1; exeCmdIn = 4'b0010;
      valRnIn = 32'd2; iIn = 1'b1; shiftOperandIn = 12'h003; pcIn = 32'h40; destIn = 4'd6;
      tick();
      checkCount++; if (aluRes_s2 !== 32'd5 || brTaken_s2 !== 1'b1) begin errCount++; $display("[TB] FAIL rst_pre_load: res %0d br %b expected 5 1", aluRes_s2, brTaken_s2); end
      rst = 1'b1;
      tick();
      checkCount++; if (aluRes_s2 !== 32'h0 || brAddr_s2 !== 32'h0 || dest_s2 !== 4'h0) begin errCount++; $display("[TB] FAIL rst_data: res %h addr %h dest %h expected 0", aluRes_s2, brAddr_s2, dest_s2); end
      checkCount++; if ({wbEn_s2, statusWe_s2, brTaken_s2, busy_s2} !== 4'b0) begin errCount++; $display("[TB] FAIL rst_ctl: got %b expected 0000", {wbEn_s2, statusWe_s2, brTaken_s2, busy_s2}); end
      rst = 1'b0;
      clearInputs();
      tick();
   endtask

   initial begin
      $display("[TB] exe_stage_mc directed tests start");
      test_reset();
      test_add();
      test_sub_fwd();
      test_val2();
      test_undef();
      test_freeze_flush_single();
      test_branch();
      test_mla_latency();
      test_mul_freeze();
      test_mul_flush();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule

// File: doc/exe_stage_mc.md
Name: exe_stage_mc

Overview:
- Parametrised successor to the ARM execute stage.
- Adds operand forwarding muxes and an owned EX/MEM output register with freeze/flush.
- Adds registered branch resolution and status-write signalling.
- Adds an iterative multi-cycle MUL/MLA unit that stalls upstream through a busy handshake.
- Sits between the ID/EX register and the memory stage.

Parameters:
- HAS_MUL, 1: 0 removes the multiplier; MUL/MLA then behave as undefined commands.
- MUL_STEP, 2: multiplier bits retired per cycle. Legal values are 1, 2, 4, 8. Multiply latency N = 32/MUL_STEP cycles.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- freeze  in  1  hold the output register and the multiplier state
- flush  in  1  insert a bubble and abort any multiply in progress
- valid_in  in  1  ID/EX slot holds a real instruction
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, i_in  in  1 each  control bits
- exe_cmd_in  in  4  ALU command
- pc_in, val_rn_in, val_rm_in, val_rs_in  in  32 each  PC+4 and register operands
- shift_operand_in  in  12  shifter operand
- imm24_in  in  24  branch offset
- dest_in  in  4  destination register
- status_in  in  4  current {N,Z,C,V}
- fwd_sel1, fwd_sel2  in  2 each  source select for Rn and Rm: 0 register, 1 fwd_mem_val, 2 fwd_wb_val, 3 register
- fwd_mem_val, fwd_wb_val  in  32 each  forwarded values
- wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  registered control
- alu_res_out, val_rm_out  out  32 each  registered result and store data (forwarded Rm)
- dest_out  out  4  registered destination
- status_out  out  4  registered next {N,Z,C,V}
- status_we  out  1  registered status-write strobe
- branch_taken  out  1  registered
- branch_addr  out  32  registered
- busy  out  1  multiplier active; upstream must stall

Behaviour:
- Reset: every output is 0, busy is 0, the multiplier counter is 0.
- Operand forwarding: op1 = fwd_sel1 mux of val_rn_in; rm = fwd_sel2 mux of val_rm_in. Rs is never forwarded.
- val2 selection, in priority order:
  - (mem_r_en_in | mem_w_en_in) & !i_in gives zero-extended shift_operand_in[11:0].
  - i_in gives zero-extended imm8 [7:0] rotated right by 2*[11:8].
  - Otherwise rm shifted by [11:7]. Shift type [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 means no shift.
- exe_cmd_in encoding:
  - 0001 MOV: val2
  - 1001 MVN: ~val2
  - 0010 ADD: op1+val2
  - 0011 ADC: op1+val2+C
  - 0100 SUB: op1-val2
  - 0101 SBC: op1-val2-!C
  - 0110 AND
  - 0111 ORR
  - 1000 EOR
  - 1010 MUL: rm*val_rs_in
  - 1011 MLA: rm*val_rs_in+op1
  - Any other value: result 0, no flag change.
  - Loads and stores use ADD.
- Flags:
  - N = res[31]; Z = (res==0).
  - Add-type ops: C = carry out, V = signed overflow.
  - Sub-type ops: C = NOT borrow, V = signed overflow.
  - Logic, MOV, MVN, MUL, MLA: N and Z only; C and V are taken from status_in.
  - status_we = valid & s_in & the instruction completes this edge.
- Branch: branch_addr = pc_in + sext(imm24_in)<<2 (mod 2^32); branch_taken = valid & b_in.
- Single-cycle ops: on an edge with !freeze & !busy, the output register loads the results.
  - If valid_in=0 or flush=1, the register loads a bubble: all enables 0, branch_taken 0, status_we 0.
  - Data fields are don't-care in a bubble.
- freeze=1 with no flush: the output register holds all values and no multiply starts. flush has priority over freeze.
- Multiply FSM states IDLE, RUN:
  - IDLE→RUN on an edge with valid_in, a MUL/MLA command, !freeze and !flush. Operands (rm, val_rs_in, op1) are captured, busy=1, and the output register loads a bubble.
  - RUN iterates MUL_STEP bits per edge while !freeze; freeze holds the counter.
  - After the N-th iteration edge the result, flags and dest are written to the output register and the FSM returns to IDLE (busy=0) on that same edge.
  - Inputs are ignored while busy.
  - flush or rst in RUN: return to IDLE next edge, busy=0, output is a bubble, no status write.
- Product is the low 32 bits; MLA wraps mod 2^32.

Test Plan:
- ADD op1=0xFFFFFFFF, val2=1, s=1 → alu_res_out=0, status_out=0b0110 (Z,C), status_we=1 after 1 edge.
- SUB 5-7, s=1, fwd_sel1=1, fwd_mem_val=5, val_rn_in=99 → res=0xFFFFFFFE, N=1, C=0, V=0.
- val2 modes:
  - i=1, shift_operand 0x4FF → val2=0xFF000000 (MOV).
  - Register ASR: rm=0x80000000, amount 4 → 0xF8000000.
  - LDR offset 0x123 → res=op1+0x123.
- MLA 7*6+3, MUL_STEP=2 → busy high for 16 cycles, then res=45, N=0, Z=0 with C,V from status_in; repeat for MUL_STEP=1 (32 cycles) and 8 (4 cycles).
- Freeze for 3 cycles mid-multiply → completion delayed by exactly 3 cycles. Flush at iteration 5 → busy drops next edge, bubble out, no status_we.
- Branch pc=0x100, imm24=0xFFFFFE → branch_addr=0xF8, branch_taken=1. Same with flush=1 → branch_taken=0. rst mid-op → all outputs 0.
